nonl_phimap_seq: RTL and testbench

NONL_PHIMAP_SEQ -- requirements
Module: nonl_phimap_seq

---
 rtl/nonl_phimap_seq.sv | 187 ++++++++++++++++++
 tb/tb_nonl_phimap_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/nonl_phimap_seq.sv
// Sequential phi-map: slot 0 = x, odd/even slots = sin/cos(k*pi*x) for k=1..nh from one shared quarter-wave LUT.
// Result valid 2*nh+2 edges after acceptance; output held in DONE until out_ready, back-to-back accept allowed.
module nonl_phimap_seq #(
    parameter int Q_ORD     = 7,
    parameter int WIDTH     = 16,
    parameter int QP        = 12,
    parameter int PHW       = 20,
    parameter int LUT_ABITS = 8,
    localparam int P        = (Q_ORD - 1) / 2,
    localparam int OSW      = $clog2(P + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         x_in,
    input  logic [OSW-1:0]           ord_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [Q_ORD*WIDTH-1:0]   nonl_x_out_packed
);

    localparam int N   = 1 << LUT_ABITS;
    localparam int AW  = LUT_ABITS + 1;
    localparam int KW  = $clog2(P + 2);
    localparam int SW  = $clog2(Q_ORD);
    localparam int SH  = PHW - 1 - QP;
    localparam longint PI_FX = 64'sd3373259426;   // pi * 2^30

    // Elaboration-time sine table entry, fixed-point Taylor series in Q30.
    function automatic logic [WIDTH-1:0] lut_entry(input int i);
        longint amp, th, th2, term, acc, r;
        amp  = (longint'(1) <<< (WIDTH - 1)) - 1;
        th   = (longint'(i) * PI_FX) / longint'(2 * N);
        th2  = (th * th) >>> 30;
        term = th;
        acc  = th;
        for (int n = 1; n <= 9; n++) begin
            term = -((term * th2) >>> 30) / longint'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        r = (acc * amp + (longint'(1) <<< 29)) >>> 30;
        if (i >= N || r > amp) r = amp;
        if (r < 0) r = 0;
        return r[WIDTH-1:0];
    endfunction

    function automatic logic [KW-1:0] clamp_nh(input logic [OSW-1:0] o);
        int v;
        v = int'(o);
        if (v < 1)
            v = 1;
        else if (v > P)
            v = P;
        return KW'(v);
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] lut_rom [0:N];
    for (genvar gi = 0; gi <= N; gi++) begin : g_rom
        localparam logic [WIDTH-1:0] ENTRY = lut_entry(gi);
        assign lut_rom[gi] = ENTRY;
    end

    logic [PHW-1:0]   phase_acc_q, phase1_q, phase1_d, x_ext;
    logic [KW-1:0]    k_q, nh_q;
    logic             sub_q;
    logic             accept, issue_en, last_d;
    logic [LUT_ABITS+1:0] ph_top;
    logic [AW-1:0]    addr_d;
    logic [KW:0]      slot_full;

    logic             a_vld, a_neg, a_last;
    logic [AW-1:0]    a_addr;
    logic [SW-1:0]    a_slot;
    logic             b_vld, b_neg, b_last;
    logic [WIDTH-1:0] lut_q;
    logic [SW-1:0]    b_slot;
    logic [WIDTH-1:0] slot_q [Q_ORD];

    assign accept   = in_valid & in_ready;
    assign x_ext    = PHW'($signed(x_in));
    assign phase1_d = x_ext << SH;
    assign issue_en = (state_q == S_RUN) && (k_q <= nh_q);

    // Only the quadrant and index bits feed the LUT, so the quarter-turn cos offset is added there alone.
    assign ph_top    = phase_acc_q[PHW-1 -: LUT_ABITS+2] + {sub_q, {LUT_ABITS{1'b0}}};
    assign addr_d    = ph_top[LUT_ABITS] ? ({1'b1, {LUT_ABITS{1'b0}}} - {1'b0, ph_top[LUT_ABITS-1:0]})
                                         : {1'b0, ph_top[LUT_ABITS-1:0]};
    assign slot_full = {k_q, 1'b0} - {{KW{1'b0}}, ~sub_q};
    assign last_d    = sub_q && (k_q == nh_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (b_vld && b_last) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = in_valid ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE:  in_ready = 1'b1;
            S_DONE:  begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_acc_q <= '0;
            phase1_q    <= '0;
            k_q         <= '0;
            nh_q        <= '0;
            sub_q       <= 1'b0;
            a_vld       <= 1'b0;
            a_neg       <= 1'b0;
            a_last      <= 1'b0;
            a_addr      <= '0;
            a_slot      <= '0;
            b_vld       <= 1'b0;
            b_neg       <= 1'b0;
            b_last      <= 1'b0;
            b_slot      <= '0;
            lut_q       <= '0;
            for (int i = 0; i < Q_ORD; i++)
                slot_q[i] <= '0;
        end else begin
            // Issue stage -> registered ROM read -> slot write.
            a_vld  <= issue_en;
            a_addr <= addr_d;
            a_neg  <= ph_top[LUT_ABITS+1];
            a_slot <= slot_full[SW-1:0];
            a_last <= last_d;

            b_vld  <= a_vld;
            lut_q  <= lut_rom[a_addr];
            b_neg  <= a_neg;
            b_slot <= a_slot;
            b_last <= a_last;

            if (issue_en) begin
                sub_q <= ~sub_q;
                if (sub_q) begin
                    phase_acc_q <= phase_acc_q + phase1_q;
                    k_q         <= k_q + 1'b1;
                end
            end

            if (b_vld)
                slot_q[b_slot] <= b_neg ? -lut_q : lut_q;

            if (accept) begin
                slot_q[0] <= x_in;
                for (int i = 1; i < Q_ORD; i++)
                    slot_q[i] <= '0;
                nh_q        <= clamp_nh(ord_sel);
                phase1_q    <= phase1_d;
                phase_acc_q <= phase1_d;
                k_q         <= KW'(1);
                sub_q       <= 1'b0;
            end
        end
    end

    for (genvar gs = 0; gs < Q_ORD; gs++) begin : g_pack
        assign nonl_x_out_packed[gs*WIDTH +: WIDTH] = slot_q[gs];
    end

endmodule

// File: tb/tb_nonl_phimap_seq.sv
// Bench for nonl_phimap_seq: fixed vectors, hold/back-to-back and reset sequences, random sweep against a real-valued model.
module tb_nonl_phimap_seq;

    localparam int Q_ORD = 7;
    localparam int WIDTH = 16;
    localparam int QP = 12;
    localparam int PHW = 20;
    localparam int LUT_ABITS = 8;
    localparam int P = 3;
    localparam int OW = Q_ORD * WIDTH;
    localparam real AMP = 32767.0;
    localparam real PI = 3.14159265358979;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [WIDTH-1:0] x_in = '0;
    logic [1:0] ord_sel = '0;
    logic in_ready, out_valid;
    logic [OW-1:0] pk;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nonl_phimap_seq dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .x_in(x_in),
        .ord_sel(ord_sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .nonl_x_out_packed(pk)
    );

    typedef struct {
        logic [15:0]   x;
        logic [1:0]    ord;
        logic [OW-1:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_tol(input string nm, input int act, input real exp, input real tol);
        real d;
        n_cmp++;
        d = real'(act) - exp;
        if (d > tol || d < -tol) begin
            n_err++;
            $display("FAIL %s: got %0d expected %f within %f", nm, act, exp, tol);
        end
    endtask

    function automatic int nh_of(input logic [1:0] o);
        int v;
        v = int'(o);
        if (v == 0) return 1;
        if (v > P) return P;
        return v;
    endfunction

    function automatic int slot_val(input int i);
        logic [15:0] s;
        s = pk[i*WIDTH +: WIDTH];
        return int'($signed(s));
    endfunction

    // Table-quantised model: phase modulo one turn, keep only quadrant+index bits, exact sine.
    function automatic real qmodel(input logic [15:0] x, input int k, input bit cs);
        longint p1, ph, top;
        p1  = longint'($signed(x)) <<< (PHW - 1 - QP);
        ph  = longint'(k) * p1 + (cs ? (longint'(1) <<< (PHW - 2)) : longint'(0));
        ph  = ph & ((longint'(1) <<< PHW) - 1);
        top = ph >>> (PHW - LUT_ABITS - 2);
        return $sin(2.0 * PI * real'(top) / real'(1 << (LUT_ABITS + 2))) * AMP;
    endfunction

    function automatic real tmodel(input logic [15:0] x, input int k, input bit cs);
        real xr;
        xr = real'(int'($signed(x))) / real'(1 << QP);
        return (cs ? $cos(real'(k) * PI * xr) : $sin(real'(k) * PI * xr)) * AMP;
    endfunction

    // Called at a negedge; offers a sample, returns edges from acceptance until out_valid.
    task automatic accept_and_wait(input logic [15:0] x, input logic [1:0] o, input bit scramble, output int lat);
        in_valid = 1'b1;
        x_in = x;
        ord_sel = o;
        #1;
        chk("in_ready_at_offer", 128'(in_ready), 128'(1));
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = scramble ? 1'($urandom) : 1'b0;
        if (scramble) begin
            x_in = 16'($urandom);
            ord_sel = 2'($urandom);
        end
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic release_out();
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_out_valid", 128'(out_valid), 128'(0));
        chk("idle_in_ready", 128'(in_ready), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vt [7];
        int lat, nh, xi;
        logic [15:0] xr;
        logic [1:0] orr;
        logic [OW-1:0] exp_hold;

        vt[0] = '{16'h0000, 2'd3, {16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000}};
        vt[1] = '{16'h0800, 2'd3, {16'h0000, 16'h8001, 16'h8001, 16'h0000, 16'h0000, 16'h7FFF, 16'h0800}};
        vt[2] = '{16'hF000, 2'd1, {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8001, 16'h0000, 16'hF000}};
        vt[3] = '{16'hF000, 2'd0, {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8001, 16'h0000, 16'hF000}};
        vt[4] = '{16'h0400, 2'd2, {16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h5A82, 16'h5A82, 16'h0400}};
        vt[5] = '{16'h0C00, 2'd2, {16'h0000, 16'h0000, 16'h0000, 16'h8001, 16'hA57E, 16'h5A82, 16'h0C00}};
        vt[6] = '{16'h8000, 2'd3, {16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h8000}};
        exp_hold = {16'h0000, 16'h0000, 16'h8001, 16'h0000, 16'h0000, 16'h7FFF, 16'h0800};

        repeat (2) @(negedge clk);
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_packed", 128'(pk), 128'(0));
        reset = 1'b1;
        #1;
        chk("post_reset_in_ready", 128'(in_ready), 128'(1));

        for (int i = 0; i < 7; i++) begin
            accept_and_wait(vt[i].x, vt[i].ord, 1'b1, lat);
            chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(2 * nh_of(vt[i].ord) + 2));
            chk($sformatf("vec%0d_packed", i), 128'(pk), 128'(vt[i].exp));
            release_out();
        end

        // Hold in DONE with a competing offer, then back-to-back acceptance.
        accept_and_wait(16'h0800, 2'd2, 1'b0, lat);
        chk("hold_latency", 128'(lat), 128'(6));
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            x_in = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("hold_packed", 128'(pk), 128'(exp_hold));
            chk("hold_out_valid", 128'(out_valid), 128'(1));
            chk("hold_in_ready", 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        accept_and_wait(16'h0400, 2'd1, 1'b1, lat);
        chk("b2b_latency", 128'(lat), 128'(4));
        chk("b2b_packed", 128'(pk), 128'({16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h5A82, 16'h5A82, 16'h0400}));
        release_out();

        // Reset three cycles into RUN, then a sample on the first edge after release.
        in_valid = 1'b1;
        x_in = 16'h0800;
        ord_sel = 2'd3;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_run_out_valid", 128'(out_valid), 128'(0));
        chk("rst_run_packed", 128'(pk), 128'(0));
        @(negedge clk);
        reset = 1'b1;
        accept_and_wait(16'hF000, 2'd1, 1'b1, lat);
        chk("after_rst_latency", 128'(lat), 128'(4));
        chk("after_rst_packed", 128'(pk), 128'(vt[2].exp));

        // Reset while in DONE.
        reset = 1'b0;
        #1;
        chk("rst_done_out_valid", 128'(out_valid), 128'(0));
        chk("rst_done_packed", 128'(pk), 128'(0));
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;

        for (int it = 0; it < 40; it++) begin
            xi = int'($urandom_range(8191, 0)) - 4096;
            xr = 16'(xi);
            orr = 2'($urandom);
            nh = nh_of(orr);
            accept_and_wait(xr, orr, 1'b1, lat);
            chk($sformatf("rnd%0d_latency", it), 128'(lat), 128'(2 * nh + 2));
            chk($sformatf("rnd%0d_slot0", it), 128'(pk[WIDTH-1:0]), 128'(xr));
            for (int k = 1; k <= P; k++) begin
                if (k <= nh) begin
                    chk_tol($sformatf("rnd%0d_sin%0d_q", it, k), slot_val(2*k-1), qmodel(xr, k, 1'b0), 1.0);
                    chk_tol($sformatf("rnd%0d_cos%0d_q", it, k), slot_val(2*k), qmodel(xr, k, 1'b1), 1.0);
                    chk_tol($sformatf("rnd%0d_sin%0d_t", it, k), slot_val(2*k-1), tmodel(xr, k, 1'b0),
                            2.0 * PI / real'(4 << LUT_ABITS) * AMP + 1.0);
                    chk_tol($sformatf("rnd%0d_cos%0d_t", it, k), slot_val(2*k), tmodel(xr, k, 1'b1),
                            2.0 * PI / real'(4 << LUT_ABITS) * AMP + 1.0);
                end else begin
                    chk($sformatf("rnd%0d_sin%0d_zero", it, k), 128'(pk[(2*k-1)*WIDTH +: WIDTH]), 128'(0));
                    chk($sformatf("rnd%0d_cos%0d_zero", it, k), 128'(pk[(2*k)*WIDTH +: WIDTH]), 128'(0));
                end
            end
            release_out();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
